id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and operand-feed logic of the 64-bit RISC-V pipeline. Captures decoded instruction state once per cycle and drives the EX-stage ALU. It supplies the forwarded operands, the 4-bit ALU control code and the store data. It also detects load-use hazards, handles stalls and flushes, and inserts bubbles.

## Interface
- XLEN, 64, datapath width
- RA_W, 5, register-address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold all ID/EX state (downstream busy)
- flush  in  1  replace next ID/EX content with a bubble (taken branch)
- id_valid  in  1  ID slot holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN  decoded values
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_funct3  in  3;  id_funct7_b5  in  1  instruction function bits
- id_alu_op  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type ALU
- id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control
- exmem_reg_write  in  1;  exmem_rd  in  RA_W;  exmem_result  in  XLEN  EX/MEM forward source
- memwb_reg_write  in  1;  memwb_rd  in  RA_W;  memwb_result  in  XLEN  MEM/WB forward source
- load_use_hazard  out  1  combinational; upstream holds IF/ID while high
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control
- ex_rd  out  RA_W;  ex_pc, ex_imm  out  XLEN  registered fields
- ex_alu_ctrl  out  4  registered ALU operation code
- ex_alu_a, ex_alu_b, ex_store_data, ex_branch_target  out  XLEN  combinational EX operands

## Operation
- Register update priority: reset > flush > stall > load_use_hazard > normal load.
- Reset: every registered field is cleared to 0, except ex_alu_ctrl, which is set to 4'b0010.
- Flush or hazard bubble: ex_valid and all six control bits are cleared to 0, ex_rd is cleared to 0, and ex_alu_ctrl is set to 4'b0010. Data fields load normally and are don't-care.
- Stall: all registers hold their values. Forwarding stays live.
- Normal: all fields are captured from the id_* inputs. Control bits are gated by id_valid, so id_valid=0 loads a bubble.
- ALU control (registered), decoded from id_alu_op, id_funct3 and id_funct7_b5:
  - alu_op 00 → 0010 (add).
  - alu_op 01 → 0110 (sub).
  - alu_op 10 or 11: funct3 111 → 0000 (AND); funct3 110 → 0001 (OR).
  - funct3 000 → 0110 only when alu_op=10 and funct7_b5=1; otherwise 0010.
  - Any other funct3 → 0010.
- Forwarding for each source rsX, using the registered rs1/rs2:
  - If exmem_reg_write, exmem_rd≠0 and exmem_rd==rsX, use exmem_result.
  - Else if memwb_reg_write, memwb_rd≠0 and memwb_rd==rsX, use memwb_result.
  - Else use the registered rsX data.
- Operand outputs:
  - ex_alu_a = forwarded rs1.
  - ex_alu_b = ex_alu_src ? ex_imm : forwarded rs2.
  - ex_store_data = forwarded rs2.
  - ex_branch_target = ex_pc + ex_imm, modulo 2^XLEN, wrap-around ignored.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2). False positives on an unused rs2 are permitted.

## Timing
- Latency: one cycle from ID to EX. Operand outputs settle combinationally in the same cycle from the registers and forward inputs.
- Hazard with stall=0: a bubble enters on the next edge and IF/ID holds upstream. On the following cycle the load sits in EX/MEM, the hazard drops, and the held instruction loads with MEM/WB forwarding available.
- stall and load_use_hazard both high: hold takes priority over the bubble, and the hazard stays asserted.
- flush together with stall or hazard: a bubble is loaded.
- Reset mid-operation: on the next edge all state matches the reset values, regardless of stall or flush.
- Writes to x0 are never forwarded, and rd=0 never raises a hazard.

## Test plan
- Reset with id_valid=1 and all inputs nonzero → ex_valid=0, all control bits 0, ex_alu_ctrl=0010, ex_pc=0.
- R-type sub: alu_op=10, funct3=000, funct7_b5=1, rs1_data=10, rs2_data=3 → next cycle ex_alu_ctrl=0110, ex_alu_a=10, ex_alu_b=3.
- Forwarding priority: registered rs1=5, exmem_rd=5 with result 0xAA, memwb_rd=5 with result 0xBB, both reg_write=1 → ex_alu_a=0xAA. Drop exmem_reg_write → ex_alu_a=0xBB. Set rs1=0 → registered data is used.
- Load-use: ex holds ld with rd=7 and ex_mem_read=1; id_rs2=7 → load_use_hazard=1, next cycle ex_valid=0 and ex_mem_read=0. With IF/ID held, the instruction loads on the following edge.
- Stall for 3 cycles with changing id_* inputs → registered outputs are unchanged. With flush and stall both high → ex_valid=0 on the next edge.
- addi with alu_src=1, imm=-1, alu_op=11, funct7_b5=1, funct3=000 → ex_alu_ctrl=0010, ex_alu_b=0xFFFF_FFFF_FFFF_FFFF. With pc=0xFFFF_FFFF_FFFF_FFFC and imm=8 → ex_branch_target=4.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register and EX operand feed of the 64-bit RISC-V pipeline.
// It captures the decoded instruction once per cycle and registers a 4-bit
// ALU control code. It forwards operands from EX/MEM and MEM/WB, and detects
// load-use hazards, which insert a bubble while IF/ID holds upstream.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   stall                    hold all ID/EX state
//   flush                    load a bubble (taken branch)
//   id_valid                 ID slot holds a real instruction
//   id_pc/id_rs1_data/
//   id_rs2_data/id_imm       decoded XLEN-wide values
//   id_rs1/id_rs2/id_rd      register addresses
//   id_funct3/id_funct7_b5/
//   id_alu_op                ALU decode inputs
//   id_alu_src ... id_branch decoded control bits
//   exmem_*/memwb_*          forwarding sources
//   load_use_hazard          combinational; upstream holds IF/ID while high
//   ex_* (control/rd/pc/imm/alu_ctrl)  registered EX-stage fields
//   ex_alu_a/ex_alu_b/ex_store_data/ex_branch_target  combinational operands
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_b5,
    input  logic [1:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            load_use_hazard,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic [RA_W-1:0] ex_rd,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [3:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_alu_a,
    output logic [XLEN-1:0] ex_alu_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_branch_target
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Control bits
    logic valid_q, valid_d;
    logic alu_src_q, alu_src_d;
    logic reg_write_q, reg_write_d;
    logic mem_read_q, mem_read_d;
    logic mem_write_q, mem_write_d;
    logic mem_to_reg_q, mem_to_reg_d;
    logic branch_q, branch_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    // Data fields
    logic [RA_W-1:0] rs1_q, rs1_d;
    logic [RA_W-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;

    logic [3:0]      alu_ctrl_dec;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // ALU control decode from alu_op / funct3 / funct7[5]
    always_comb begin
        alu_ctrl_dec = ALU_ADD;
        case (id_alu_op)
            2'b00: alu_ctrl_dec = ALU_ADD;
            2'b01: alu_ctrl_dec = ALU_SUB;
            default: begin
                case (id_funct3)
                    3'b111: alu_ctrl_dec = ALU_AND;
                    3'b110: alu_ctrl_dec = ALU_OR;
                    // Only R-type uses funct7[5] to pick sub; addi ignores it
                    3'b000: alu_ctrl_dec = (id_alu_op == 2'b10 && id_funct7_b5)
                                           ? ALU_SUB : ALU_ADD;
                    default: alu_ctrl_dec = ALU_ADD;
                endcase
            end
        endcase
    end

    assign load_use_hazard = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                             ((rd_q == id_rs1) | (rd_q == id_rs2));

    // Priority: flush > stall > hazard > normal. Flush overrides a stall,
    // so the load path is taken whenever flush is set or stall is clear.
    always_comb begin
        valid_d      = valid_q;
        alu_src_d    = alu_src_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        branch_d     = branch_q;
        rd_d         = rd_q;
        alu_ctrl_d   = alu_ctrl_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        if (flush || !stall) begin
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            pc_d       = id_pc;
            imm_d      = id_imm;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            if (flush || load_use_hazard || !id_valid) begin
                valid_d      = 1'b0;
                alu_src_d    = 1'b0;
                reg_write_d  = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                branch_d     = 1'b0;
                rd_d         = '0;
                alu_ctrl_d   = ALU_ADD;
            end else begin
                valid_d      = 1'b1;
                alu_src_d    = id_alu_src;
                reg_write_d  = id_reg_write;
                mem_read_d   = id_mem_read;
                mem_write_d  = id_mem_write;
                mem_to_reg_d = id_mem_to_reg;
                branch_d     = id_branch;
                rd_d         = id_rd;
                alu_ctrl_d   = alu_ctrl_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            branch_q     <= 1'b0;
            rd_q         <= '0;
            alu_ctrl_q   <= ALU_ADD;
            rs1_q        <= '0;
            rs2_q        <= '0;
            pc_q         <= '0;
            imm_q        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            branch_q     <= branch_d;
            rd_q         <= rd_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs1_q)
            fwd_rs1 = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs1_q)
            fwd_rs1 = memwb_result;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs2_q)
            fwd_rs2 = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs2_q)
            fwd_rs2 = memwb_result;
    end

    assign ex_valid         = valid_q;
    assign ex_reg_write     = reg_write_q;
    assign ex_mem_read      = mem_read_q;
    assign ex_mem_write     = mem_write_q;
    assign ex_mem_to_reg    = mem_to_reg_q;
    assign ex_branch        = branch_q;
    assign ex_rd            = rd_q;
    assign ex_pc            = pc_q;
    assign ex_imm           = imm_q;
    assign ex_alu_ctrl      = alu_ctrl_q;
    assign ex_alu_a         = fwd_rs1;
    assign ex_alu_b         = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data    = fwd_rs2;
    assign ex_branch_target = pc_q + imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Table-driven bench for id_ex_stage. Each record holds the inputs for one
// cycle plus the expected hazard flag (before the edge) and the expected EX
// outputs (after the edge). Expectations go to a scoreboard queue when a
// record is driven and are popped and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RA_W = 5;

    logic            clk = 1'b0;
    logic            reset, stall, flush, id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    logic            id_funct7_b5;
    logic [1:0]      id_alu_op;
    logic            id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic            id_mem_to_reg, id_branch;
    logic            exmem_reg_write, memwb_reg_write;
    logic [RA_W-1:0] exmem_rd, memwb_rd;
    logic [XLEN-1:0] exmem_result, memwb_result;
    logic            load_use_hazard;
    logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic            ex_mem_to_reg, ex_branch;
    logic [RA_W-1:0] ex_rd;
    logic [XLEN-1:0] ex_pc, ex_imm;
    logic [3:0]      ex_alu_ctrl;
    logic [XLEN-1:0] ex_alu_a, ex_alu_b, ex_store_data, ex_branch_target;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7_b5(id_funct7_b5), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_hazard(load_use_hazard), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
        .ex_store_data(ex_store_data), .ex_branch_target(ex_branch_target)
    );

    typedef struct {
        logic        rst, stl, fl, vld;
        logic [63:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [1:0]  op;
        logic        src, rw, mr, mw, m2r, br;
        logic        xw;
        logic [4:0]  xrd;
        logic [63:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [63:0] wres;
        // expectations
        logic        e_haz, e_valid;
        logic [3:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic [4:0]  e_ctl;   // {reg_write, mem_read, mem_write, mem_to_reg, branch}
        logic        chk;     // data fields are meaningful
        logic [63:0] e_pc, e_a, e_b, e_sd, e_bt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t dv();
        vec_t v;
        v.rst = 0; v.stl = 0; v.fl = 0; v.vld = 1;
        v.pc = 64'h1000; v.d1 = 64'd10; v.d2 = 64'd3; v.imm = 64'd0;
        v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = 5'd3;
        v.f3 = 3'b000; v.f7 = 0; v.op = 2'b10;
        v.src = 0; v.rw = 1; v.mr = 0; v.mw = 0; v.m2r = 0; v.br = 0;
        v.xw = 0; v.xrd = 5'd0; v.xres = 64'd0;
        v.ww = 0; v.wrd = 5'd0; v.wres = 64'd0;
        v.e_haz = 0; v.e_valid = 1; v.e_ctrl = 4'b0010; v.e_rd = 5'd3;
        v.e_ctl = 5'b10000; v.chk = 1;
        v.e_pc = 64'h1000; v.e_a = 64'd10; v.e_b = 64'd3; v.e_sd = 64'd3;
        v.e_bt = 64'h1000;
        return v;
    endfunction

    function automatic vec_t bub(input vec_t vi);
        vec_t v = vi;
        v.e_valid = 0; v.e_ctrl = 4'b0010; v.e_rd = 5'd0; v.e_ctl = 5'd0;
        v.chk = 0;
        return v;
    endfunction

    function automatic vec_t rexp(input vec_t vi);
        vec_t v = bub(vi);
        v.chk = 1; v.e_pc = '0; v.e_a = '0; v.e_b = '0; v.e_sd = '0; v.e_bt = '0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; stall = v.stl; flush = v.fl; id_valid = v.vld;
        id_pc = v.pc; id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_funct3 = v.f3; id_funct7_b5 = v.f7; id_alu_op = v.op;
        id_alu_src = v.src; id_reg_write = v.rw; id_mem_read = v.mr;
        id_mem_write = v.mw; id_mem_to_reg = v.m2r; id_branch = v.br;
        exmem_reg_write = v.xw; exmem_rd = v.xrd; exmem_result = v.xres;
        memwb_reg_write = v.ww; memwb_rd = v.wrd; memwb_result = v.wres;
    endtask

    task automatic cmp(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        drive(v);
        n_vec++;
        #1;
        cmp("load_use_hazard", idx, 64'(load_use_hazard), 64'(v.e_haz));
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp("ex_valid", idx, 64'(ex_valid), 64'(e.e_valid));
        cmp("ex_alu_ctrl", idx, 64'(ex_alu_ctrl), 64'(e.e_ctrl));
        cmp("ex_rd", idx, 64'(ex_rd), 64'(e.e_rd));
        cmp("ex_ctl", idx,
            64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
            64'(e.e_ctl));
        if (e.chk) begin
            cmp("ex_pc", idx, ex_pc, e.e_pc);
            cmp("ex_alu_a", idx, ex_alu_a, e.e_a);
            cmp("ex_alu_b", idx, ex_alu_b, e.e_b);
            cmp("ex_store_data", idx, ex_store_data, e.e_sd);
            cmp("ex_branch_target", idx, ex_branch_target, e.e_bt);
        end
    endtask

    initial begin
        vec_t v, s;

        // ---------------- single-cycle vectors ----------------
        // reset wins with everything nonzero, stall and flush high
        v = dv(); v.rst = 1; v.stl = 1; v.fl = 1; v.pc = 64'h1234; v.imm = 64'h55;
        v.d1 = 64'h66; v.d2 = 64'h77; v.rs1 = 4; v.rs2 = 5; v.rd = 6;
        v.mr = 1; v.mw = 1; v.m2r = 1; v.br = 1; v.src = 1; v.f3 = 3'b111;
        tbl.push_back(rexp(v));
        // R-type sub
        v = dv(); v.f7 = 1; v.e_ctrl = 4'b0110; tbl.push_back(v);
        // R-type add
        v = dv(); v.d1 = 64'h100; v.d2 = 64'h23; v.rd = 4; v.imm = 64'h20; v.pc = 64'h2000;
        v.e_rd = 4; v.e_pc = 64'h2000; v.e_a = 64'h100; v.e_b = 64'h23; v.e_sd = 64'h23;
        v.e_bt = 64'h2020; tbl.push_back(v);
        // AND
        v = dv(); v.f3 = 3'b111; v.d1 = 64'hF0; v.d2 = 64'h3C; v.rd = 5;
        v.e_ctrl = 4'b0000; v.e_rd = 5; v.e_a = 64'hF0; v.e_b = 64'h3C; v.e_sd = 64'h3C;
        tbl.push_back(v);
        // ORI with immediate operand
        v = dv(); v.op = 2'b11; v.f3 = 3'b110; v.src = 1; v.imm = 64'h40; v.d1 = 64'd1;
        v.d2 = 64'h99; v.rd = 6;
        v.e_ctrl = 4'b0001; v.e_rd = 6; v.e_a = 64'd1; v.e_b = 64'h40; v.e_sd = 64'h99;
        v.e_bt = 64'h1040; tbl.push_back(v);
        // branch: alu_op 01 is sub whatever funct3 says
        v = dv(); v.op = 2'b01; v.f3 = 3'b111; v.br = 1; v.rw = 0; v.rd = 0;
        v.d1 = 64'd5; v.d2 = 64'd5; v.imm = 64'h100; v.pc = 64'h2000;
        v.e_ctrl = 4'b0110; v.e_rd = 0; v.e_ctl = 5'b00001; v.e_pc = 64'h2000;
        v.e_a = 64'd5; v.e_b = 64'd5; v.e_sd = 64'd5; v.e_bt = 64'h2100; tbl.push_back(v);
        // load rd=7: alu_op 00 is add regardless of funct3
        v = dv(); v.op = 2'b00; v.f3 = 3'b110; v.mr = 1; v.m2r = 1; v.src = 1;
        v.imm = 64'd8; v.rd = 7; v.d1 = 64'h1000; v.d2 = 64'h22;
        v.e_rd = 7; v.e_ctl = 5'b11010; v.e_a = 64'h1000; v.e_b = 64'd8;
        v.e_sd = 64'h22; v.e_bt = 64'h1008; tbl.push_back(v);
        // addi (funct7_b5=1 ignored) using rs2=7 -> hazard bubble
        v = dv(); v.op = 2'b11; v.f7 = 1; v.src = 1; v.imm = '1; v.rs2 = 7; v.rd = 9;
        v.d1 = 64'h30; v.d2 = 64'h44; v.e_haz = 1; tbl.push_back(bub(v));
        // held addi loads, rs2 now from MEM/WB
        v.ww = 1; v.wrd = 7; v.wres = 64'h77; v.e_haz = 0;
        v.e_valid = 1; v.e_ctrl = 4'b0010; v.e_rd = 9; v.e_ctl = 5'b10000; v.chk = 1;
        v.e_pc = 64'h1000; v.e_a = 64'h30; v.e_b = '1; v.e_sd = 64'h77;
        v.e_bt = 64'hFFF; tbl.push_back(v);
        // forwarding priority: EX/MEM over MEM/WB
        v = dv(); v.rs1 = 5; v.d1 = 64'h11; v.xw = 1; v.xrd = 5; v.xres = 64'hAA;
        v.ww = 1; v.wrd = 5; v.wres = 64'hBB; v.mw = 1;
        v.e_a = 64'hAA; v.e_ctl = 5'b10100; tbl.push_back(v);
        // EX/MEM not writing -> MEM/WB
        v = dv(); v.rs1 = 5; v.d1 = 64'h11; v.xrd = 5; v.xres = 64'hAA;
        v.ww = 1; v.wrd = 5; v.wres = 64'hBB; v.e_a = 64'hBB; tbl.push_back(v);
        // x0 never forwarded
        v = dv(); v.rs1 = 0; v.d1 = 64'h11; v.xw = 1; v.xrd = 0; v.xres = 64'hAA;
        v.ww = 1; v.wrd = 0; v.wres = 64'hBB; v.e_a = 64'h11; tbl.push_back(v);
        // branch target wraps
        v = dv(); v.pc = 64'hFFFF_FFFF_FFFF_FFFC; v.imm = 64'd8;
        v.e_pc = 64'hFFFF_FFFF_FFFF_FFFC; v.e_bt = 64'd4; tbl.push_back(v);
        // id_valid=0 loads a bubble
        v = dv(); v.vld = 0; v.f3 = 3'b111; v.mr = 1; tbl.push_back(bub(v));
        // load to x0
        v = dv(); v.op = 2'b00; v.mr = 1; v.src = 1; v.imm = 64'h18; v.rd = 0;
        v.d1 = 64'h200; v.e_rd = 0; v.e_ctl = 5'b11000; v.e_a = 64'h200;
        v.e_b = 64'h18; v.e_bt = 64'h1018; tbl.push_back(v);
        // consumer of x0: no hazard
        v = dv(); v.rs1 = 0; v.rs2 = 0; tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 0) begin
                // bring the DUT out of power-up state before the table proper
                @(negedge clk);
                v = dv(); v.rst = 1; drive(v);
                @(posedge clk);
            end
            apply(tbl[i], i);
        end

        // ---------------- multi-cycle corner sequences ----------------
        // load in EX, then stall 3 cycles with hazard and changing inputs
        s = dv(); s.op = 2'b00; s.rd = 7; s.mr = 1; s.m2r = 1; s.src = 1;
        s.imm = 64'h10; s.d1 = 64'h500; s.d2 = 64'h66; s.rs1 = 2; s.rs2 = 3;
        s.pc = 64'h3000;
        s.e_rd = 7; s.e_ctl = 5'b11010; s.e_pc = 64'h3000; s.e_a = 64'h500;
        s.e_b = 64'h10; s.e_sd = 64'h66; s.e_bt = 64'h3010;
        apply(s, 100);
        v = s; v.stl = 1; v.rs1 = 7; v.op = 2'b10; v.f3 = 3'b111; v.pc = 64'h4000;
        v.d1 = 64'h999; v.rd = 8; v.mr = 0; v.e_haz = 1;
        apply(v, 101);
        v = s; v.stl = 1; v.rs1 = 1; v.rs2 = 7; v.pc = 64'h5000; v.rd = 0;
        v.f3 = 3'b110; v.e_haz = 1;
        apply(v, 102);
        // forwarding stays live during the stall
        v = s; v.stl = 1; v.rs1 = 7; v.pc = 64'h6000; v.xw = 1; v.xrd = 2;
        v.xres = 64'hCAFE; v.e_haz = 1; v.e_a = 64'hCAFE;
        apply(v, 103);
        // flush beats stall
        v = s; v.stl = 1; v.fl = 1; v.rs1 = 7; v.e_haz = 1;
        apply(bub(v), 104);
        // flush alone
        v = dv(); v.fl = 1; v.rs1 = 7;
        apply(bub(v), 105);
        // normal OR after the bubbles
        v = dv(); v.f3 = 3'b110; v.rs1 = 7; v.e_ctrl = 4'b0001;
        apply(v, 106);
        // reset mid-operation with stall and flush high
        v = dv(); v.rst = 1; v.stl = 1; v.fl = 1; v.mr = 1; v.rd = 7;
        apply(rexp(v), 107);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // absolute time bound so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
